// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: feeds each accepted word bit-serially into an external
// "0,0,...,1" sequence detector and counts the matches that belong to it.
// The word is framed as WIDTH data bits followed by two 1-bits. The two 1-bits
// flush the detector back to its start state before the next word.
// The detector output lags det_x by two edges. A 2-deep tag pipeline marks which
// detector pulses belong to data bits.
// Optional build macro: SEQ_SCAN_LSB_FIRST_EN shifts in_data[0] out first.
// Without it, in_data[WIDTH-1] goes first.
module seq_scan_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_x,
  input  logic             det_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_count,
  output logic [15:0]      total_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       idx_q;
  logic [1:0]       tag_q;   // [0] = bit presented last cycle, [1] = two cycles ago
  logic [4:0]       cnt_q;
  logic [15:0]      total_q;
  logic [16:0]      sum;
  logic             cur_bit;

`ifdef SEQ_SCAN_LSB_FIRST_EN
  assign cur_bit = shreg_q[0];
`else
  assign cur_bit = shreg_q[WIDTH-1];
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshakes, serial bit and saturating total
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    det_x     = 1'b1;
    sum       = {1'b0, total_q} + 17'(cnt_q);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        det_x = cur_bit;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (idx_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, bit index, tag pipeline, match counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      tag_q <= {tag_q[0], state_q == SHIFT};
      // A pulse counts only when its attributed bit was a data bit.
      if (det_y && tag_q[1]) cnt_q <= cnt_q + 5'd1;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q <= in_data;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
`ifdef SEQ_SCAN_LSB_FIRST_EN
          shreg_q <= shreg_q >> 1;
`else
          shreg_q <= shreg_q << 1;
`endif
          idx_q <= (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;
        end
        DRAIN: idx_q <= idx_q + 5'd1;
        DONE: begin
          if (out_ready) total_q <= sum[16] ? 16'hFFFF : sum[15:0];
        end
        default: ;
      endcase
    end
  end

  assign out_count   = cnt_q;
  assign total_count = total_q;

endmodule
